// File: rtl/imem_fetch_unit_if.sv
// Fetch-unit bus: run control, instruction-memory port, redirect input
// and the IF/ID handshake toward decode, grouped for the fetch stage.
interface imem_fetch_unit_if;
    logic        start;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  start,
        output imem_pc,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output halted,
        output fetch_count
    );

    modport slave (
        output start,
        input  imem_pc,
        output imem_instruction,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch stage: owns the PC, IF/ID register and IDLE/RUN/HALT
// run control. Ports: clk, rst_n (async, active-low), bus (master side).
module imem_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 256
) (
    input logic              clk,
    input logic              rst_n,
    imem_fetch_unit_if.master bus
);
    localparam logic [31:0] LAST_PC = 32'((MEM_WORDS - 1) * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] redir_pc;
    logic        redir_ok;
    logic        adv;
    logic        at_last;

    assign redir_pc = bus.redirect_pc & ~32'h3;
    assign redir_ok = (redir_pc <= LAST_PC);
    assign adv      = !id_valid_q || bus.id_ready;
    assign at_last  = (pc_q == LAST_PC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // A same-cycle redirect decides whether start lands in HALT.
                if (bus.start) begin
                    state_d = (bus.redirect_valid && !redir_ok) ? HALT : RUN;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    state_d = redir_ok ? RUN : HALT;
                end else if (adv && at_last) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (bus.redirect_valid) begin
                    state_d = redir_ok ? RUN : HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fetch_count_d = fetch_count_q;
        // Redirect wins over both load and stall; IF/ID becomes a bubble.
        priority case (1'b1)
            bus.redirect_valid: begin
                pc_d       = redir_pc;
                id_valid_d = 1'b0;
                id_instr_d = '0;
            end
            (state_q == RUN) && adv: begin
                id_valid_d    = 1'b1;
                id_instr_d    = bus.imem_instruction;
                id_pc_d       = pc_q;
                id_pc_plus4_d = pc_q + 32'd4;
                fetch_count_d = fetch_count_q + 32'd1;
                pc_d          = at_last ? pc_q : pc_q + 32'd4;
            end
            (state_q == HALT) && id_valid_q && bus.id_ready: begin
                id_valid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign bus.imem_pc     = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.fetch_count = fetch_count_q;
    assign bus.halted      = (state_q == HALT);
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized scoreboard bench for imem_fetch_unit with a behavioural
// fetch model; a separate monitor compares outputs every cycle.
module tb_imem_fetch_unit;
    localparam logic [31:0] RPC  = 32'd12;
    localparam int          MW   = 16;
    localparam logic [31:0] LAST = 32'((MW - 1) * 4);

    localparam logic [31:0] LW  = 32'h0001_2083;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0031_00B3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_unit_if bus();

    imem_fetch_unit #(
        .RESET_PC (RPC),
        .MEM_WORDS(MW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [MW];

    assign bus.imem_instruction =
        (bus.imem_pc[31:6] == 26'd0) ? mem[bus.imem_pc[5:2]] : 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic [31:0] m_count;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a[31:6] != 26'd0) return 32'h0;
        return mem[a[5:2]];
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = RPC;
        m_valid = 1'b0;
        m_instr = '0;
        m_idpc  = '0;
        m_idpc4 = '0;
        m_count = '0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        adv;
        exp_t        e;
        tgt = bus.redirect_pc & ~32'h3;
        adv = !m_valid || bus.id_ready;
        if (m_mode == 0) begin
            if (bus.redirect_valid) m_pc = tgt;
            if (bus.start)
                m_mode = (bus.redirect_valid && tgt > LAST) ? 2 : 1;
        end else if (bus.redirect_valid) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            m_instr = '0;
            m_mode  = (tgt > LAST) ? 2 : 1;
        end else if (m_mode == 1) begin
            if (adv) begin
                m_valid = 1'b1;
                m_instr = rd(m_pc);
                m_idpc  = m_pc;
                m_idpc4 = m_pc + 32'd4;
                m_count = m_count + 32'd1;
                e.pc    = m_pc;
                e.instr = m_instr;
                e.cnt   = m_count;
                q.push_back(e);
                if (m_pc == LAST) m_mode = 2;
                else m_pc = m_pc + 32'd4;
            end
        end else begin
            if (m_valid && bus.id_ready) m_valid = 1'b0;
        end
    endtask

    task automatic cyc(input bit st, input bit rv,
                       input logic [31:0] rp, input bit rdy);
        @(negedge clk);
        bus.start          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        bus.id_ready       = rdy;
        @(posedge clk);
        if (rst_n) model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 15) == 0,
                32'($urandom_range(0, 80)),
                $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks every cycle, and on each new load pops the scoreboard.
    initial begin
        logic [31:0] last_cnt;
        exp_t        e;
        last_cnt = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                q.delete();
                last_cnt = '0;
                chk("rst_imem_pc", bus.imem_pc, RPC);
                chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
                chk("rst_id_instr", bus.id_instr, 32'd0);
                chk("rst_id_pc", bus.id_pc, 32'd0);
                chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);
                chk("rst_fetch_count", bus.fetch_count, 32'd0);
                chk("rst_halted", 32'(bus.halted), 32'd0);
            end else begin
                chk("imem_pc", bus.imem_pc, m_pc);
                chk("halted", 32'(bus.halted), 32'(m_mode == 2));
                chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
                chk("id_instr", bus.id_instr, m_instr);
                chk("id_pc", bus.id_pc, m_idpc);
                chk("id_pc_plus4", bus.id_pc_plus4, m_idpc4);
                chk("fetch_count", bus.fetch_count, m_count);
                if (bus.fetch_count != last_cnt) begin
                    if (q.size() == 0) begin
                        chk("sb_unexpected_load", bus.fetch_count, last_cnt);
                    end else begin
                        e = q.pop_front();
                        chk("sb_pc", bus.id_pc, e.pc);
                        chk("sb_instr", bus.id_instr, e.instr);
                        chk("sb_count", bus.fetch_count, e.cnt);
                    end
                    last_cnt = bus.fetch_count;
                end
                chk("sb_pending", 32'(q.size()), 32'd0);
            end
        end
    end

    initial begin
        bus.start          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        mem[3] = LW;
        mem[4] = LW;
        for (int i = 5; i < 9; i++) mem[i] = NOP;
        mem[9] = ADD;
        model_reset();

        idle(3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Start, first loads 12 and 16, then a 3-cycle stall.
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        idle(2, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);

        // Redirect while stalled at 20, unaligned target lands on 36.
        cyc(1'b0, 1'b1, 32'h0000_0027, 1'b0);
        idle(1, 1'b1);

        // Run off the end of memory; start is ignored in HALT.
        idle(12, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);

        // Recovery, out-of-range redirect from RUN, recovery again.
        cyc(1'b0, 1'b1, 32'd8, 1'b1);
        idle(2, 1'b1);
        cyc(1'b0, 1'b1, 32'h0000_0400, 1'b1);
        idle(3, 1'b1);
        cyc(1'b0, 1'b1, 32'd8, 1'b1);
        idle(2, 1'b1);

        rand_phase(300);

        // Asynchronous reset between edges during a stall.
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        idle(3, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        idle(2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        idle(4, 1'b1);

        rand_phase(300);
        idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
